// File: rtl/conv_window_scheduler_if.sv
// Pixel-stream, ILB, window and conv-unit handshake bundle for conv_window_scheduler.
// master = scheduler side, slave = surrounding datapath / stimulus side.
interface conv_window_scheduler_if #(
   parameter int IMG_WIDTH  = 64,
   parameter int IMG_HEIGHT = 48
);
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam int NW = $clog2(IMG_WIDTH * IMG_HEIGHT + 1);

   logic          frame_start;
   logic          pix_valid;
   logic [7:0]    pix_data;
   logic          pix_ready;
   logic          ilb_wr_en;
   logic [7:0]    ilb_wr_data;
   logic [CW-1:0] ilb_wr_col;
   logic          win_shift;
   logic          conv_start;
   logic          conv_done;
   logic [RW-1:0] conv_row;
   logic [CW-1:0] conv_col;
   logic [NW-1:0] conv_count;
   logic          frame_done;
   logic          busy;

   modport master (
      input  frame_start, pix_valid, pix_data, conv_done,
      output pix_ready, ilb_wr_en, ilb_wr_data, ilb_wr_col, win_shift,
             conv_start, conv_row, conv_col, conv_count, frame_done, busy
   );

   modport slave (
      output frame_start, pix_valid, pix_data, conv_done,
      input  pix_ready, ilb_wr_en, ilb_wr_data, ilb_wr_col, win_shift,
             conv_start, conv_row, conv_col, conv_count, frame_done, busy
   );
endinterface

// File: rtl/conv_window_scheduler.sv
// Frame sequencer: accepts raster pixels, drives ILB write and window shift,
// and issues one convolution per fully-inside KSIZE x KSIZE window.
module conv_window_scheduler #(
   parameter int IMG_WIDTH  = 64,
   parameter int IMG_HEIGHT = 48,
   parameter int KSIZE      = 7
) (
   input logic                   clk,
   input logic                   rst,
   conv_window_scheduler_if.master bus
);
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam int NW = $clog2(IMG_WIDTH * IMG_HEIGHT + 1);

   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
   localparam logic [CW-1:0] K_COL    = CW'(KSIZE - 1);
   localparam logic [RW-1:0] K_ROW    = RW'(KSIZE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCEPT,
      S_WRITE,
      S_SHIFT,
      S_CONV_REQ,
      S_CONV_WAIT,
      S_FRAME_DONE
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] wr_col_q, wr_col_d;
   logic [7:0]    wr_data_q, wr_data_d;
   logic [RW-1:0] conv_row_q, conv_row_d;
   logic [CW-1:0] conv_col_q, conv_col_d;
   logic [NW-1:0] conv_count_q, conv_count_d;
   logic          advance;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         col_q        <= '0;
         row_q        <= '0;
         wr_col_q     <= '0;
         wr_data_q    <= '0;
         conv_row_q   <= '0;
         conv_col_q   <= '0;
         conv_count_q <= '0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         wr_col_q     <= wr_col_d;
         wr_data_q    <= wr_data_d;
         conv_row_q   <= conv_row_d;
         conv_col_q   <= conv_col_d;
         conv_count_q <= conv_count_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      wr_col_d     = wr_col_q;
      wr_data_d    = wr_data_q;
      conv_row_d   = conv_row_q;
      conv_col_d   = conv_col_q;
      conv_count_d = conv_count_q;
      advance      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.frame_start) begin
               row_d        = '0;
               col_d        = '0;
               conv_count_d = '0;
               state_d      = S_ACCEPT;
            end
         end
         S_ACCEPT: begin
            if (bus.pix_valid) begin
               wr_data_d = bus.pix_data;
               wr_col_d  = col_q;
               state_d   = S_WRITE;
            end
         end
         S_WRITE: state_d = S_SHIFT;
         S_SHIFT: begin
            if (row_q >= K_ROW && col_q >= K_COL) begin
               conv_row_d = row_q - K_ROW;
               conv_col_d = col_q - K_COL;
               state_d    = S_CONV_REQ;
            end else begin
               advance = 1'b1;
            end
         end
         S_CONV_REQ: state_d = S_CONV_WAIT;
         S_CONV_WAIT: begin
            if (bus.conv_done) begin
               conv_count_d = conv_count_q + NW'(1);
               advance      = 1'b1;
            end
         end
         S_FRAME_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Raster advance shared by the border (SHIFT) and interior (CONV_WAIT) paths.
      if (advance) begin
         if (col_q == COL_LAST && row_q == ROW_LAST) begin
            state_d = S_FRAME_DONE;
         end else if (col_q == COL_LAST) begin
            col_d   = '0;
            row_d   = row_q + RW'(1);
            state_d = S_ACCEPT;
         end else begin
            col_d   = col_q + CW'(1);
            state_d = S_ACCEPT;
         end
      end
   end

   assign bus.pix_ready   = (state_q == S_ACCEPT);
   assign bus.ilb_wr_en   = (state_q == S_WRITE);
   assign bus.win_shift   = (state_q == S_SHIFT);
   assign bus.conv_start  = (state_q == S_CONV_REQ);
   assign bus.frame_done  = (state_q == S_FRAME_DONE);
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.ilb_wr_data = wr_data_q;
   assign bus.ilb_wr_col  = wr_col_q;
   assign bus.conv_row    = conv_row_q;
   assign bus.conv_col    = conv_col_q;
   assign bus.conv_count  = conv_count_q;
endmodule

// File: tb/tb_conv_window_scheduler.sv
// Bench for conv_window_scheduler: a small 8x6/K=3 instance under directed and
// randomized cycle-level checks, plus a default-size instance run over one full frame.
module tb_conv_window_scheduler;
   localparam int SW = 8;
   localparam int SH = 6;
   localparam int SK = 3;
   localparam int SN = SW * SH;
   localparam int SCONV = (SW - SK + 1) * (SH - SK + 1);

   localparam int LW = 64;
   localparam int LH = 48;
   localparam int LK = 7;
   localparam int LCONV = (LW - LK + 1) * (LH - LK + 1);

   logic clk;
   logic s_rst;
   logic l_rst;

   int errors = 0;
   int checks = 0;
   int exp_cc;

   int s_cs, s_fd, s_hs;
   int l_cs = 0, l_fd = 0, l_hs = 0, l_wr = 0, l_col_bad = 0;
   int l_last_row = -1, l_last_col = -1;
   logic l_prev_start = 1'b0;

   conv_window_scheduler_if #(.IMG_WIDTH(SW), .IMG_HEIGHT(SH)) s_if ();
   conv_window_scheduler_if l_if ();

   conv_window_scheduler #(.IMG_WIDTH(SW), .IMG_HEIGHT(SH), .KSIZE(SK)) u_small (
      .clk (clk),
      .rst (s_rst),
      .bus (s_if.master)
   );

   conv_window_scheduler u_large (
      .clk (clk),
      .rst (l_rst),
      .bus (l_if.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string pfx);
      chk({pfx, "_pix_ready"}, 32'(s_if.pix_ready), 0);
      chk({pfx, "_wr_en"}, 32'(s_if.ilb_wr_en), 0);
      chk({pfx, "_wr_data"}, 32'(s_if.ilb_wr_data), 0);
      chk({pfx, "_wr_col"}, 32'(s_if.ilb_wr_col), 0);
      chk({pfx, "_win_shift"}, 32'(s_if.win_shift), 0);
      chk({pfx, "_conv_start"}, 32'(s_if.conv_start), 0);
      chk({pfx, "_conv_row"}, 32'(s_if.conv_row), 0);
      chk({pfx, "_conv_col"}, 32'(s_if.conv_col), 0);
      chk({pfx, "_conv_count"}, 32'(s_if.conv_count), 0);
      chk({pfx, "_frame_done"}, 32'(s_if.frame_done), 0);
      chk({pfx, "_busy"}, 32'(s_if.busy), 0);
   endtask

   // Small-instance event monitor, sampled after the testbench's negedge drives settle.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (s_if.conv_start) s_cs++;
         if (s_if.frame_done) s_fd++;
         if (s_if.pix_ready && s_if.pix_valid) s_hs++;
      end
   end

   // Large-instance responder: pixels always offered, conv_done one cycle after conv_start.
   initial begin
      l_if.pix_valid = 1'b1;
      l_if.pix_data  = '0;
      l_if.conv_done = 1'b0;
      forever begin
         @(negedge clk);
         l_if.conv_done = l_prev_start;
         l_prev_start   = l_if.conv_start;
         if (l_if.pix_ready && l_if.pix_valid) l_hs++;
         if (l_if.ilb_wr_en) begin
            if (int'(l_if.ilb_wr_col) != (l_wr % LW)) l_col_bad++;
            l_wr++;
         end
         if (l_if.conv_start) begin
            l_cs++;
            l_last_row = int'(l_if.conv_row);
            l_last_col = int'(l_if.conv_col);
         end
         if (l_if.frame_done) l_fd++;
         l_if.pix_data = 8'($urandom_range(0, 255));
      end
   end

   task automatic start_frame();
      s_cs = 0;
      s_fd = 0;
      s_hs = 0;
      exp_cc = 0;
      s_if.frame_start = 1'b1;
      @(negedge clk);
      s_if.frame_start = 1'b0;
      chk("start_busy", 32'(s_if.busy), 1);
      chk("start_ready", 32'(s_if.pix_ready), 1);
      chk("start_count", 32'(s_if.conv_count), 0);
   endtask

   // Drives one pixel from the ACCEPT state through to the following ACCEPT/FRAME_DONE.
   task automatic run_pixel(input int idx, input int gap, input int dly, input bit abort,
                            output bit aborted);
      int r, c, nwait;
      bit interior;
      logic [7:0] d;
      aborted  = 1'b0;
      r        = idx / SW;
      c        = idx % SW;
      interior = (r >= SK - 1) && (c >= SK - 1);
      d        = 8'($urandom_range(0, 255));

      s_if.pix_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
         chk("idle_ready", 32'(s_if.pix_ready), 1);
         s_if.frame_start = (g == 0);
         s_if.conv_done   = 1'b1;
         @(negedge clk);
         chk("idle_count", 32'(s_if.conv_count), 32'(exp_cc));
         chk("idle_wr_en", 32'(s_if.ilb_wr_en), 0);
      end
      s_if.frame_start = 1'b0;
      s_if.conv_done   = 1'b0;

      s_if.pix_valid = 1'b1;
      s_if.pix_data  = d;
      chk("hs_ready", 32'(s_if.pix_ready), 1);
      @(negedge clk);
      s_if.pix_valid = 1'($urandom_range(0, 1));
      s_if.pix_data  = ~d;
      chk("wr_en", 32'(s_if.ilb_wr_en), 1);
      chk("wr_data", 32'(s_if.ilb_wr_data), 32'(d));
      chk("wr_col", 32'(s_if.ilb_wr_col), 32'(c));
      chk("wr_ready", 32'(s_if.pix_ready), 0);
      s_if.frame_start = 1'b1;
      s_if.conv_done   = 1'b1;
      @(negedge clk);
      s_if.frame_start = 1'b0;
      chk("shift", 32'(s_if.win_shift), 1);
      chk("shift_wr_en", 32'(s_if.ilb_wr_en), 0);
      chk("shift_count", 32'(s_if.conv_count), 32'(exp_cc));
      @(negedge clk);

      if (interior) begin
         chk("conv_start", 32'(s_if.conv_start), 1);
         chk("conv_row", 32'(s_if.conv_row), 32'(r - (SK - 1)));
         chk("conv_col", 32'(s_if.conv_col), 32'(c - (SK - 1)));
         chk("req_count", 32'(s_if.conv_count), 32'(exp_cc));
         s_if.conv_done = (dly == 0);
         nwait = (dly == 0) ? 1 : dly;
         for (int j = 0; j < nwait; j++) begin
            @(negedge clk);
            chk("wait_ready", 32'(s_if.pix_ready), 0);
            chk("wait_start", 32'(s_if.conv_start), 0);
            if (abort && j == 0) begin
               s_rst = 1'b0;
               #1;
               chk_zero("abort");
               s_if.conv_done = 1'b0;
               s_if.pix_valid = 1'b0;
               aborted = 1'b1;
               return;
            end
            if (j == dly - 1) s_if.conv_done = 1'b1;
         end
         @(negedge clk);
         s_if.conv_done = 1'b0;
         exp_cc++;
         chk("done_count", 32'(s_if.conv_count), 32'(exp_cc));
      end else begin
         chk("border_no_start", 32'(s_if.conv_start), 0);
         s_if.conv_done = 1'b0;
      end

      if (idx != SN - 1) chk("ready_back", 32'(s_if.pix_ready), 1);
   endtask

   task automatic run_frame(input int mode);
      bit ab;
      int gap, dly;
      start_frame();
      for (int i = 0; i < SN; i++) begin
         gap = (mode == 1) ? int'($urandom_range(0, 2)) : 0;
         dly = (mode == 1) ? ((i == 25) ? 5 : int'($urandom_range(0, 5))) : 1;
         run_pixel(i, gap, dly, (mode == 2 && i == 20), ab);
         if (ab) return;
      end
      s_if.pix_valid = 1'b0;
      chk("fd_pulse", 32'(s_if.frame_done), 1);
      chk("fd_count", 32'(s_if.conv_count), SCONV);
      @(negedge clk);
      chk("fd_low", 32'(s_if.frame_done), 0);
      chk("fd_idle", 32'(s_if.busy), 0);
      chk("fd_hold_count", 32'(s_if.conv_count), SCONV);
      chk("fd_starts", 32'(s_cs), SCONV);
      chk("fd_pulses", 32'(s_fd), 1);
      chk("fd_handshakes", 32'(s_hs), SN);
      repeat (2) @(negedge clk);
      chk("idle_hold_count", 32'(s_if.conv_count), SCONV);
   endtask

   initial begin
      bit seen;
      s_rst = 1'b0;
      l_rst = 1'b0;
      s_if.frame_start = 1'b0;
      s_if.pix_valid   = 1'b0;
      s_if.pix_data    = '0;
      s_if.conv_done   = 1'b0;
      l_if.frame_start = 1'b0;
      repeat (3) @(negedge clk);
      chk_zero("rst");
      s_rst = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", 32'(s_if.busy), 0);

      run_frame(0);
      run_frame(1);
      run_frame(2);
      repeat (3) @(negedge clk);
      chk("abort_no_fd", 32'(s_fd), 0);
      s_rst = 1'b1;
      @(negedge clk);
      chk("abort_idle", 32'(s_if.busy), 0);
      run_frame(0);

      l_rst = 1'b1;
      @(negedge clk);
      l_if.frame_start = 1'b1;
      @(negedge clk);
      l_if.frame_start = 1'b0;
      seen = 1'b0;
      for (int cyc = 0; cyc < 30000 && !seen; cyc++) begin
         @(negedge clk);
         if (l_fd != 0) seen = 1'b1;
      end
      chk("large_frame_done_seen", 32'(seen), 1);
      repeat (3) @(negedge clk);
      chk("large_handshakes", 32'(l_hs), LW * LH);
      chk("large_starts", 32'(l_cs), LCONV);
      chk("large_count", 32'(l_if.conv_count), LCONV);
      chk("large_fd_pulses", 32'(l_fd), 1);
      chk("large_col_bad", 32'(l_col_bad), 0);
      chk("large_last_row", 32'(l_last_row), LH - LK);
      chk("large_last_col", 32'(l_last_col), LW - LK);
      chk("large_idle", 32'(l_if.busy), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
